// File: rtl/alu_controller.sv
// alu_controller: RV32I ALU operation decode from alu_op/funct3/funct7, registered output.
// Optional: define ALU_CTRL_ILLEGAL_EN to add the registered alu_illegal flag.
module alu_controller (
    input  logic       clk,
    input  logic       nreset,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [1:0] alu_op,
    output logic [3:0] alu_ctrl
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic       alu_illegal
`endif
);
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    logic [3:0] dec;
    logic       bad;
    logic [3:0] next_ctrl;

    // Decode to {alt, f3}; illegal encodings are flagged and forced to ADD below
    always_comb begin
        dec = 4'b0000;
        bad = 1'b0;
        case (alu_op)
            2'b01: dec = funct3[2] ? {3'b001, funct3[1]} : 4'b1000;
            2'b10: begin
                dec = {funct7[5], funct3};
                bad = !(funct7 == F7_BASE || (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            2'b11: begin
                dec = {funct3 == 3'b101 && funct7[5], funct3};
                bad = (funct3 == 3'b101 && !(funct7 == F7_BASE || funct7 == F7_ALT))
                   || (funct3 == 3'b001 && funct7 != F7_BASE);
            end
            default: dec = 4'b0000;
        endcase
    end

    assign next_ctrl = bad ? 4'b0000 : dec;

    // Register the select; async reset forces ADD
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) alu_ctrl <= 4'b0000;
        else         alu_ctrl <= next_ctrl;
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    // Illegal flag aligned with alu_ctrl
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) alu_illegal <= 1'b0;
        else         alu_illegal <= bad;
    end
`endif
endmodule

// File: tb/tb_alu_controller.sv
// tb_alu_controller: scoreboard bench for alu_controller (honours ALU_CTRL_ILLEGAL_EN).
module tb_alu_controller;
    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct7 = 7'b0000000;
    logic [1:0] alu_op = 2'b00;
    logic [3:0] alu_ctrl;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       alu_illegal;
`endif

    typedef struct packed {
        logic [3:0] ctrl;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    alu_controller dut (
        .clk(clk),
        .nreset(nreset),
        .funct3(funct3),
        .funct7(funct7),
        .alu_op(alu_op)
        ,
        .alu_ctrl(alu_ctrl)
`ifdef ALU_CTRL_ILLEGAL_EN
        ,
        .alu_illegal(alu_illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_ctrl(input string name, input logic [3:0] want);
        total++;
        if (alu_ctrl !== want) begin
            bad++;
            $display("FAIL %s: alu_ctrl=%b expected=%b", name, alu_ctrl, want);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] want, input logic want_ill);
        exp_t e;
        @(negedge clk);
        alu_op = op;
        funct3 = f3;
        funct7 = f7;
        e.ctrl = want;
        e.ill  = want_ill;
        exp_q.push_back(e);
    endtask

    // Monitor: output is valid every cycle after an issued vector
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_ctrl("scoreboard", e.ctrl);
`ifdef ALU_CTRL_ILLEGAL_EN
                total++;
                if (alu_illegal !== e.ill) begin
                    bad++;
                    $display("FAIL illegal_flag: alu_illegal=%b expected=%b (ctrl exp %b)", alu_illegal, e.ill, e.ctrl);
                end
`endif
            end
        end
    end

    initial begin
        // Reset with arbitrary inputs
        alu_op = 2'b10;
        funct3 = 3'b100;
        funct7 = 7'b0000000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_ctrl("reset_hold", 4'b0000);
`ifdef ALU_CTRL_ILLEGAL_EN
        total++;
        if (alu_illegal !== 1'b0) begin
            bad++;
            $display("FAIL reset_illegal: alu_illegal=%b expected=0", alu_illegal);
        end
`endif
        nreset = 1'b1;

        // R-type
        drive(2'b10, 3'b100, 7'b0000000, 4'b0100, 1'b0);
        drive(2'b10, 3'b000, 7'b0000000, 4'b0000, 1'b0);
        drive(2'b10, 3'b101, 7'b0100000, 4'b1101, 1'b0);
        drive(2'b10, 3'b000, 7'b0100000, 4'b1000, 1'b0);
        drive(2'b10, 3'b111, 7'b0000000, 4'b0111, 1'b0);
        drive(2'b10, 3'b001, 7'b0000000, 4'b0001, 1'b0);

        // Latency: XOR then ADD; old value must hold until the next edge
        drive(2'b10, 3'b100, 7'b0000000, 4'b0100, 1'b0);
        drive(2'b10, 3'b000, 7'b0000000, 4'b0000, 1'b0);
        #1;
        check_ctrl("latency_hold", 4'b0100);

        // I-type
        drive(2'b11, 3'b000, 7'b0100000, 4'b0000, 1'b0);
        drive(2'b11, 3'b101, 7'b0100000, 4'b1101, 1'b0);
        drive(2'b11, 3'b101, 7'b0000000, 4'b0101, 1'b0);
        drive(2'b11, 3'b111, 7'b1010101, 4'b0111, 1'b0);
        drive(2'b11, 3'b001, 7'b0000000, 4'b0001, 1'b0);
        drive(2'b11, 3'b010, 7'b1111111, 4'b0010, 1'b0);

        // Branch
        drive(2'b01, 3'b000, 7'b0000000, 4'b1000, 1'b0);
        drive(2'b01, 3'b001, 7'b0100000, 4'b1000, 1'b0);
        drive(2'b01, 3'b100, 7'b0000000, 4'b0010, 1'b0);
        drive(2'b01, 3'b111, 7'b0000000, 4'b0011, 1'b0);
        drive(2'b01, 3'b011, 7'b0000000, 4'b1000, 1'b0);

        // Memory/address: funct fields ignored
        drive(2'b00, 3'b101, 7'b0100000, 4'b0000, 1'b0);
        drive(2'b00, 3'b111, 7'b1111111, 4'b0000, 1'b0);

        // Illegal encodings decode to ADD
        drive(2'b10, 3'b100, 7'b0100000, 4'b0000, 1'b1);
        drive(2'b10, 3'b100, 7'b0000000, 4'b0100, 1'b0);
        drive(2'b10, 3'b000, 7'b0000001, 4'b0000, 1'b1);
        drive(2'b11, 3'b101, 7'b0000001, 4'b0000, 1'b1);
        drive(2'b11, 3'b001, 7'b0100000, 4'b0000, 1'b1);

        // Mid-stream async reset: load SLTU, then clear without a clock edge
        drive(2'b01, 3'b110, 7'b0000000, 4'b0011, 1'b0);
        repeat (4) begin
            if (exp_q.size() > 0) @(posedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
        check_ctrl("pre_async_reset", 4'b0011);
        #2;
        nreset = 1'b0;
        #1;
        check_ctrl("async_reset", 4'b0000);
        @(negedge clk);
        check_ctrl("async_reset_held", 4'b0000);
        nreset = 1'b1;

        // First edge after release loads current decode (SLTU)
        drive(2'b01, 3'b110, 7'b0000000, 4'b0011, 1'b0);
        repeat (4) begin
            if (exp_q.size() > 0) @(posedge clk);
        end
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_drain: pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_controller.md
Name: alu_controller

Overview:
- Decodes the main-control ALU class (alu_op) plus RISC-V RV32I funct3/funct7 fields into a 4-bit ALU operation select (alu_ctrl).
- Sits between the instruction decoder / main controller and the ALU in the RV32I datapath.
- Output is registered: one clock of latency.

Parameters:
- None. All field widths are fixed: funct3 3b, funct7 7b, alu_op 2b, alu_ctrl 4b.

Ports:
- clk  input  1  system clock, rising-edge active.
- nreset  input  1  asynchronous, active-low reset.
- funct3  input  3  instruction bits [14:12].
- funct7  input  7  instruction bits [31:25].
- alu_op  input  2  operation class from main control.
- alu_ctrl  output  4  ALU operation select, registered.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on nreset. While nreset=0, alu_ctrl=4'b0000 (ADD).
- alu_ctrl updates on each rising clk edge from the current inputs. Latency is 1 cycle. No handshake.
- ALU encoding is {alt, f3}:
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011
  - XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111
- alu_op=00 (load/store/AUIPC address): ADD 0000. funct fields are ignored.
- alu_op=01 (branch compare), selected by funct3:
  - 000/001 (BEQ/BNE): SUB 1000
  - 100/101 (BLT/BGE): SLT 0010
  - 110/111 (BLTU/BGEU): SLTU 0011
  - 010/011 (reserved): SUB 1000
- alu_op=10 (R-type register-register):
  - Legal: funct7=0000000 gives {0,funct3}.
  - Legal: funct7=0100000 with funct3=000 gives SUB 1000; with funct3=101 gives SRA 1101.
  - Any other funct7, or 0100000 with any other funct3, is illegal and yields ADD 0000.
- alu_op=11 (I-type register-immediate):
  - funct3=101: funct7=0000000 gives SRL 0101; funct7=0100000 gives SRAI 1101; otherwise illegal, yields 0000.
  - funct3=001: funct7=0000000 gives SLL 0001; otherwise illegal, yields 0000.
  - All other funct3 give {0,funct3}; funct7 is ignored because it is immediate bits. ADDI never becomes SUB.
- An nreset assertion mid-stream clears alu_ctrl immediately, with no clock needed. The first edge after release loads the decode of the current inputs.
- X/undriven inputs are not required to be handled. Decode is a full case with a default of ADD.

Optional Feature:
- Macro: ALU_CTRL_ILLEGAL_EN.
- When defined:
  - Adds output port alu_illegal (1 bit, registered, same cycle alignment as alu_ctrl).
  - Reset value is 0.
  - Set to 1 for exactly the illegal R-type/I-type encodings listed above; 0 otherwise.
  - alu_ctrl behaviour is unchanged.
- When undefined: the port and its logic do not exist, and illegal encodings silently decode to ADD.

Test Plan:
- Reset: hold nreset=0 with arbitrary inputs -> alu_ctrl=0000. Assert nreset low mid-operation -> 0000 immediately, without waiting for a clock edge.
- R-type: alu_op=10 with each vector applied, alu_ctrl checked one clk later:
  - funct3=100, funct7=0000000 -> 0100 (XOR)
  - funct3=000, funct7=0000000 -> 0000 (ADD)
  - funct3=101, funct7=0100000 -> 1101 (SRA)
  - funct3=000, funct7=0100000 -> 1000 (SUB)
- Latency: change the inputs from the XOR vector to the ADD vector -> alu_ctrl still 0100 before the next rising edge, 0000 after it.
- I-type: alu_op=11:
  - funct3=000, funct7=0100000 -> 0000 (ADDI, not SUB)
  - funct3=101, funct7=0100000 -> 1101
  - funct3=111 -> 0111
- Branch/memory:
  - alu_op=01: funct3=000 -> 1000; funct3=100 -> 0010; funct3=111 -> 0011.
  - alu_op=00: any funct fields -> 0000.
- Illegal (build with ALU_CTRL_ILLEGAL_EN defined): alu_op=10, funct3=100, funct7=0100000 -> alu_ctrl=0000, alu_illegal=1. Next cycle with a legal XOR -> alu_illegal=0.
